morse_disp_ctrl: RTL and testbench



---
 rtl/morse_disp_ctrl.sv | 140 ++++++++++++++
 tb/tb_morse_disp_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_disp_ctrl.sv
// Morse display sequencer: arbitrates char pushes, backspace and clear into shift-register commands.
// Optional DISPCTRL_DROP_CNT_EN adds a saturating drop_cnt output for discarded/merged requests.
module morse_disp_ctrl #(
   parameter int         DEPTH  = 8,
   parameter bit         SCROLL = 1'b1,
   parameter logic [7:0] BLANK  = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   input  logic       bksp_req,
   input  logic       clear_req,
   output logic       sr_en,
   output logic       sr_dir,
   output logic [7:0] sr_data,
   output logic [3:0] count,
   output logic       full,
   output logic       empty,
   output logic       busy
`ifdef DISPCTRL_DROP_CNT_EN
   ,
   output logic [7:0] drop_cnt
`endif
);

   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   typedef enum logic [1:0] {IDLE, PUSH, POP, CLR} state_t;

   state_t     state, state_nx;
   logic       bksp_pend, bksp_pend_nx;
   logic       clr_pend, clr_pend_nx;
   logic [3:0] count_nx;
   logic [3:0] clr_cnt, clr_cnt_nx;
   logic       sr_dir_nx;
   logic [7:0] sr_data_nx;
   logic       clr_eff, bk_eff;

   assign sr_en = (state != IDLE);
   assign busy  = (state != IDLE);
   assign full  = (count == DEPTH_C);
   assign empty = (count == 4'd0);

   // Same-cycle pulses are seen by IDLE arbitration so a request in cycle N shifts in N+1
   assign clr_eff = clr_pend | clear_req;
   assign bk_eff  = bksp_pend | bksp_req;

   always_comb begin
      char_ready   = !rst && (state == IDLE) && !bksp_pend && !clr_pend &&
                     !bksp_req && !clear_req && (SCROLL || !full);
      state_nx     = state;
      clr_pend_nx  = clr_pend | clear_req;
      bksp_pend_nx = bksp_pend | bksp_req;
      count_nx     = count;
      clr_cnt_nx   = clr_cnt;
      sr_dir_nx    = sr_dir;
      sr_data_nx   = sr_data;
      case (state)
         IDLE: begin
            // Every IDLE branch consumes whatever is pending; clear subsumes backspace
            clr_pend_nx  = 1'b0;
            bksp_pend_nx = 1'b0;
            if (clr_eff) begin
               state_nx   = CLR;
               clr_cnt_nx = 4'd0;
               sr_dir_nx  = 1'b1;
               sr_data_nx = BLANK;
            end else if (bk_eff) begin
               if (count != 4'd0) begin
                  state_nx   = POP;
                  sr_dir_nx  = 1'b1;
                  sr_data_nx = BLANK;
               end
            end else if (char_valid && char_ready) begin
               state_nx   = PUSH;
               sr_dir_nx  = 1'b0;
               sr_data_nx = char_data;
            end
         end
         PUSH: begin
            state_nx = IDLE;
            if (count != DEPTH_C) count_nx = count + 4'd1;
         end
         POP: begin
            state_nx = IDLE;
            if (count != 4'd0) count_nx = count - 4'd1;
         end
         CLR: begin
            if (clr_cnt == DEPTH_C - 4'd1) begin
               state_nx = IDLE;
               count_nx = 4'd0;
            end else begin
               clr_cnt_nx = clr_cnt + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bksp_pend <= 1'b0;
         clr_pend  <= 1'b0;
         count     <= 4'd0;
         clr_cnt   <= 4'd0;
         sr_dir    <= 1'b0;
         sr_data   <= BLANK;
      end else begin
         state     <= state_nx;
         bksp_pend <= bksp_pend_nx;
         clr_pend  <= clr_pend_nx;
         count     <= count_nx;
         clr_cnt   <= clr_cnt_nx;
         sr_dir    <= sr_dir_nx;
         sr_data   <= sr_data_nx;
      end
   end

`ifdef DISPCTRL_DROP_CNT_EN
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   always_comb begin
      drop_inc = 2'd0;
      if (bksp_req && bksp_pend) drop_inc = drop_inc + 2'd1;
      if (clear_req && clr_pend) drop_inc = drop_inc + 2'd1;
      if ((state == IDLE) && !clr_eff && bk_eff && (count == 4'd0)) drop_inc = drop_inc + 2'd1;
      drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};
   end

   always_ff @(posedge clk) begin
      if (rst) drop_cnt <= 8'd0;
      else     drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end
`endif

endmodule

// File: tb/tb_morse_disp_ctrl.sv
// Self-checking bench for morse_disp_ctrl: directed scenarios plus a randomized command-sequence model.
module tb_morse_disp_ctrl;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       char_valid = 1'b0, char_valid_ns = 1'b0;
   logic [7:0] char_data = 8'h00;
   logic       bksp_req = 1'b0, clear_req = 1'b0;
   logic       char_ready, sr_en, sr_dir, full, empty, busy;
   logic [7:0] sr_data;
   logic [3:0] count;
   logic       char_ready_ns, sr_en_ns, sr_dir_ns, full_ns, empty_ns, busy_ns;
   logic [7:0] sr_data_ns;
   logic [3:0] count_ns;
`ifdef DISPCTRL_DROP_CNT_EN
   logic [7:0] drop_cnt, drop_cnt_ns;
`endif

   morse_disp_ctrl #(.DEPTH(DEPTH), .SCROLL(1'b1), .BLANK(8'hFF)) dut (
      .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
      .char_ready(char_ready), .bksp_req(bksp_req), .clear_req(clear_req),
      .sr_en(sr_en), .sr_dir(sr_dir), .sr_data(sr_data), .count(count),
      .full(full), .empty(empty), .busy(busy)
`ifdef DISPCTRL_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   morse_disp_ctrl #(.DEPTH(DEPTH), .SCROLL(1'b0), .BLANK(8'hFF)) dut_ns (
      .clk(clk), .rst(rst), .char_valid(char_valid_ns), .char_data(char_data),
      .char_ready(char_ready_ns), .bksp_req(bksp_req), .clear_req(clear_req),
      .sr_en(sr_en_ns), .sr_dir(sr_dir_ns), .sr_data(sr_data_ns), .count(count_ns),
      .full(full_ns), .empty(empty_ns), .busy(busy_ns)
`ifdef DISPCTRL_DROP_CNT_EN
      , .drop_cnt(drop_cnt_ns)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int busy_cyc = 0;

   typedef struct {
      int         cyc;
      logic       dir;
      logic [7:0] data;
   } cmd_t;

   cmd_t cmd_q[$];
   int   acc_q[$];
   cmd_t mon_c;

   // Observed shift commands and handshakes, stamped with the cycle they occurred in
   always @(negedge clk) begin
      if (sr_en === 1'b1) begin
         mon_c.cyc  = cyc;
         mon_c.dir  = sr_dir;
         mon_c.data = sr_data;
         cmd_q.push_back(mon_c);
      end
      if (char_valid && char_ready) acc_q.push_back(cyc);
      if (busy === 1'b1) busy_cyc++;
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      cmd_q.delete();
      acc_q.delete();
      busy_cyc = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      char_valid = 1'b0;
      char_valid_ns = 1'b0;
      bksp_req = 1'b0;
      clear_req = 1'b0;
      tick(2);
      rst = 1'b0;
      clear_mon();
   endtask

   task automatic drive_char(input logic [7:0] d, input bit ns, output bit ok);
      ok = 1'b0;
      char_data = d;
      if (ns) char_valid_ns = 1'b1;
      else    char_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (ns ? char_ready_ns : char_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      char_valid = 1'b0;
      char_valid_ns = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout data=%h ns=%0d", d, ns);
      end
   endtask

   task automatic pulse_bksp();
      bksp_req = 1'b1;
      tick(1);
      bksp_req = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      @(negedge clk);
      checks++; if (sr_en !== 1'b0) begin failures++; $display("FAIL reset_sr_en got=%b exp=0", sr_en); end
      checks++; if (sr_dir !== 1'b0) begin failures++; $display("FAIL reset_sr_dir got=%b exp=0", sr_dir); end
      checks++; if (sr_data !== 8'hFF) begin failures++; $display("FAIL reset_sr_data got=%h exp=ff", sr_data); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_char_ready got=%b exp=0", char_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({empty, full, char_ready} !== 3'b101) begin failures++; $display("FAIL post_reset_flags got=%b exp=101", {empty, full, char_ready}); end
      tick(1);
      clear_mon();
   endtask

   task automatic test_push3();
      logic [7:0] p[3] = '{8'h79, 8'h24, 8'h30};
      bit ok;
      do_reset();
      foreach (p[i]) drive_char(p[i], 1'b0, ok);
      tick(3);
      checks++; if (cmd_q.size() != 3) begin failures++; $display("FAIL push3_cmds got=%0d exp=3", cmd_q.size()); end
      for (int i = 0; i < 3 && i < cmd_q.size() && i < acc_q.size(); i++) begin
         checks++;
         if (cmd_q[i].dir !== 1'b0 || cmd_q[i].data !== p[i] || cmd_q[i].cyc != acc_q[i] + 1) begin
            failures++;
            $display("FAIL push3_cmd%0d got dir=%b data=%h cyc=%0d exp dir=0 data=%h cyc=%0d",
                     i, cmd_q[i].dir, cmd_q[i].data, cmd_q[i].cyc, p[i], acc_q[i] + 1);
         end
      end
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL push3_count got=%0d exp=3", count); end
      checks++; if (busy_cyc != 3) begin failures++; $display("FAIL push3_busy_cycles got=%0d exp=3", busy_cyc); end
   endtask

   task automatic test_scroll();
      logic [7:0] d[9];
      bit ok;
      int bad;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         d[i] = 8'($urandom_range(0, 255));
         drive_char(d[i], 1'b0, ok);
      end
      tick(2);
      checks++; if (cmd_q.size() != 9) begin failures++; $display("FAIL scroll_cmds got=%0d exp=9", cmd_q.size()); end
      bad = 0;
      for (int i = 0; i < 9 && i < cmd_q.size(); i++)
         if (cmd_q[i].dir !== 1'b0 || cmd_q[i].data !== d[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL scroll_data got_bad=%0d exp_bad=0", bad); end
      checks++; if ({count, full} !== {4'd8, 1'b1}) begin failures++; $display("FAIL scroll_full got count=%0d full=%b exp count=8 full=1", count, full); end
   endtask

   task automatic test_noscroll();
      logic [7:0] d9;
      bit ok, seen;
      do_reset();
      for (int i = 0; i < 8; i++) drive_char(8'(8'h10 + i), 1'b1, ok);
      tick(1);
      checks++; if ({count_ns, full_ns} !== {4'd8, 1'b1}) begin failures++; $display("FAIL noscroll_full got count=%0d full=%b exp count=8 full=1", count_ns, full_ns); end
      d9 = 8'($urandom_range(0, 255));
      char_data = d9;
      char_valid_ns = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (char_ready_ns) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL noscroll_ready_while_full got=1 exp=0"); end
      pulse_bksp();
      drive_char(d9, 1'b1, ok);
      tick(2);
      checks++;
      if (sr_dir_ns !== 1'b0 || sr_data_ns !== d9 || count_ns !== 4'd8) begin
         failures++;
         $display("FAIL noscroll_held_char got dir=%b data=%h count=%0d exp dir=0 data=%h count=8",
                  sr_dir_ns, sr_data_ns, count_ns, d9);
      end
   endtask

   task automatic test_bksp();
      int b[2];
      bit ok;
      do_reset();
      drive_char(8'h06, 1'b0, ok);
      drive_char(8'h5B, 1'b0, ok);
      tick(2);
      clear_mon();
      b[0] = cyc;
      pulse_bksp();
      tick(2);
      b[1] = cyc;
      pulse_bksp();
      tick(3);
      checks++; if (cmd_q.size() != 2) begin failures++; $display("FAIL bksp_cmds got=%0d exp=2", cmd_q.size()); end
      for (int i = 0; i < 2 && i < cmd_q.size(); i++) begin
         checks++;
         if (cmd_q[i].dir !== 1'b1 || cmd_q[i].data !== 8'hFF || cmd_q[i].cyc != b[i] + 1) begin
            failures++;
            $display("FAIL bksp_pop%0d got dir=%b data=%h cyc=%0d exp dir=1 data=ff cyc=%0d",
                     i, cmd_q[i].dir, cmd_q[i].data, cmd_q[i].cyc, b[i] + 1);
         end
      end
      checks++; if ({count, empty} !== {4'd0, 1'b1}) begin failures++; $display("FAIL bksp_empty got count=%0d empty=%b exp count=0 empty=1", count, empty); end
      pulse_bksp();
      tick(3);
      checks++; if (cmd_q.size() != 2) begin failures++; $display("FAIL bksp_at_empty_cmds got=%0d exp=2", cmd_q.size()); end
`ifdef DISPCTRL_DROP_CNT_EN
      checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
   endtask

   task automatic test_clear_combo();
      logic [7:0] x;
      int n;
      bit ok;
      do_reset();
      for (int i = 0; i < 5; i++) drive_char(8'(8'h40 + i), 1'b0, ok);
      tick(2);
      clear_mon();
      x = 8'($urandom_range(0, 255));
      n = cyc;
      clear_req = 1'b1;
      bksp_req = 1'b1;
      char_valid = 1'b1;
      char_data = x;
      tick(1);
      clear_req = 1'b0;
      bksp_req = 1'b0;
      drive_char(x, 1'b0, ok);
      tick(2);
      checks++; if (cmd_q.size() != 9) begin failures++; $display("FAIL clr_cmds got=%0d exp=9", cmd_q.size()); end
      for (int i = 0; i < 8 && i < cmd_q.size(); i++) begin
         checks++;
         if (cmd_q[i].dir !== 1'b1 || cmd_q[i].data !== 8'hFF || cmd_q[i].cyc != n + 1 + i) begin
            failures++;
            $display("FAIL clr_shift%0d got dir=%b data=%h cyc=%0d exp dir=1 data=ff cyc=%0d",
                     i, cmd_q[i].dir, cmd_q[i].data, cmd_q[i].cyc, n + 1 + i);
         end
      end
      if (cmd_q.size() > 8) begin
         checks++;
         if (cmd_q[8].dir !== 1'b0 || cmd_q[8].data !== x) begin
            failures++;
            $display("FAIL clr_then_push got dir=%b data=%h exp dir=0 data=%h", cmd_q[8].dir, cmd_q[8].data, x);
         end
      end
      checks++;
      if (acc_q.size() != 1 || acc_q[0] != n + 9) begin
         failures++;
         $display("FAIL clr_char_wait got accepts=%0d first=%0d exp accepts=1 cyc=%0d",
                  acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : -1, n + 9);
      end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL clr_count got=%0d exp=1", count); end
   endtask

   task automatic test_reset_mid_clr();
      int n;
      bit ok;
      do_reset();
      for (int i = 0; i < 3; i++) drive_char(8'(8'h20 + i), 1'b0, ok);
      tick(2);
      clear_mon();
      n = cyc;
      pulse_clear();
      tick(3);
      rst = 1'b1;
      tick(1);
      checks++;
      if ({sr_en, busy, count} !== {1'b0, 1'b0, 4'd0}) begin
         failures++;
         $display("FAIL rst_mid_clr got sr_en=%b busy=%b count=%0d exp sr_en=0 busy=0 count=0", sr_en, busy, count);
      end
      rst = 1'b0;
      tick(12);
      checks++;
      if (cmd_q.size() != 4 || cmd_q[cmd_q.size() - 1].cyc != n + 4) begin
         failures++;
         $display("FAIL rst_mid_clr_cmds got=%0d exp=4 ending cyc=%0d", cmd_q.size(), n + 4);
      end
   endtask

   task automatic test_bksp_during_push();
      bit ok;
      do_reset();
      for (int i = 0; i < 3; i++) drive_char(8'(8'h60 + i), 1'b0, ok);
      tick(2);
      clear_mon();
      drive_char(8'h3F, 1'b0, ok);
      pulse_bksp();
      tick(4);
      checks++;
      if (cmd_q.size() != 2) begin
         failures++;
         $display("FAIL push_bksp_cmds got=%0d exp=2", cmd_q.size());
      end else begin
         checks++;
         if (cmd_q[0].dir !== 1'b0 || cmd_q[1].dir !== 1'b1 || cmd_q[1].cyc != cmd_q[0].cyc + 2) begin
            failures++;
            $display("FAIL push_bksp_order got dirs=%b%b gap=%0d exp dirs=01 gap=2",
                     cmd_q[0].dir, cmd_q[1].dir, cmd_q[1].cyc - cmd_q[0].cyc);
         end
      end
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL push_bksp_count got=%0d exp=3", count); end
   endtask

   // Model: each accepted char is one push, each backspace with digits present one pop, a clear DEPTH pops
   task automatic test_random();
      cmd_t exp_q[$];
      cmd_t e;
      int   push_cyc[$];
      int   mcount, r, bad;
      logic [7:0] d;
      bit ok;
      do_reset();
      mcount = 0;
      repeat (80) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            d = 8'($urandom_range(0, 255));
            drive_char(d, 1'b0, ok);
            e.cyc = 0; e.dir = 1'b0; e.data = d;
            exp_q.push_back(e);
            mcount = (mcount < DEPTH) ? mcount + 1 : DEPTH;
            if ($urandom_range(0, 1) == 0) tick($urandom_range(0, 3));
         end else if (r < 9) begin
            pulse_bksp();
            if (mcount > 0) begin
               e.cyc = 0; e.dir = 1'b1; e.data = 8'hFF;
               exp_q.push_back(e);
               mcount--;
            end
            tick(1);
         end else begin
            pulse_clear();
            for (int i = 0; i < DEPTH; i++) begin
               e.cyc = 0; e.dir = 1'b1; e.data = 8'hFF;
               exp_q.push_back(e);
            end
            mcount = 0;
            tick(DEPTH + 1);
         end
      end
      tick(12);
      checks++; if (cmd_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_cmd_count got=%0d exp=%0d", cmd_q.size(), exp_q.size()); end
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++)
         if (cmd_q[i].dir !== exp_q[i].dir || cmd_q[i].data !== exp_q[i].data) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rand_cmd_seq got_bad=%0d exp_bad=0", bad); end
      foreach (cmd_q[i]) if (cmd_q[i].dir === 1'b0) push_cyc.push_back(cmd_q[i].cyc);
      bad = 0;
      for (int i = 0; i < acc_q.size() && i < push_cyc.size(); i++)
         if (push_cyc[i] != acc_q[i] + 1) bad++;
      checks++;
      if (bad != 0 || push_cyc.size() != acc_q.size()) begin
         failures++;
         $display("FAIL rand_latency got_bad=%0d pushes=%0d accepts=%0d exp_bad=0", bad, push_cyc.size(), acc_q.size());
      end
      checks++; if (count !== 4'(mcount)) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", count, mcount); end
   endtask

   initial begin
      test_reset();
      test_push3();
      test_scroll();
      test_noscroll();
      test_bksp();
      test_clear_combo();
      test_reset_mid_clr();
      test_bksp_during_push();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
